// File: rtl/lsu_axi_bridge_pkg.sv
// Shared constants and FSM state type for the LSU-to-AXI bridge.
// Widths that are fixed by the core side live here; AXI widths are top-level parameters.
package lsu_axi_bridge_pkg;

    localparam int unsigned CORE_ADDR_W = 64;
    localparam int unsigned STRB_W      = 8;
    localparam int unsigned RESP_W      = 2;

    localparam logic [RESP_W-1:0] AXI_RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RADDR = 3'd1,
        ST_RDATA = 3'd2,
        ST_WREQ  = 3'd3,
        ST_WRESP = 3'd4
    } state_t;

endpackage

// File: rtl/lsu_axi_bridge.sv
// Single-outstanding bridge from a simple LSU request port to AXI read/write channels.
// Valids and readies decode from registered state only, never from AXI inputs.
module lsu_axi_bridge
    import lsu_axi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 64
) (
    input  logic                   lsu_clk_i,
    input  logic                   lsu_rst_i,

    input  logic                   lsu_ren_i,
    input  logic                   lsu_wen_i,
    input  logic [CORE_ADDR_W-1:0] lsu_addr_i,
    input  logic [DATA_W-1:0]      lsu_wdata_i,
    input  logic [STRB_W-1:0]      lsu_wmask_i,
    output logic [DATA_W-1:0]      lsu_rdata_o,
    output logic                   lsu_done_o,
    output logic                   lsu_busy_o,
    output logic                   lsu_err_o,

    output logic [ADDR_W-1:0]      axi_araddr_o,
    output logic                   axi_arvalid_o,
    input  logic                   axi_arready_i,
    input  logic [DATA_W-1:0]      axi_rdata_i,
    input  logic [RESP_W-1:0]      axi_rresp_i,
    input  logic                   axi_rvalid_i,
    output logic                   axi_rready_o,

    output logic [ADDR_W-1:0]      axi_awaddr_o,
    output logic                   axi_awvalid_o,
    input  logic                   axi_awready_i,
    output logic [DATA_W-1:0]      axi_wdata_o,
    output logic [STRB_W-1:0]      axi_wstrb_o,
    output logic                   axi_wvalid_o,
    input  logic                   axi_wready_i,
    input  logic [RESP_W-1:0]      axi_bresp_i,
    input  logic                   axi_bvalid_i,
    output logic                   axi_bready_o
);

    state_t              r_state;
    state_t              w_next;
    logic                r_aw_done;
    logic                r_w_done;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wmask;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_done;
    logic                r_err;

    logic                w_ar_hs;
    logic                w_r_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_accept;

    // Upper core address bits are intentionally dropped.
    if (ADDR_W < CORE_ADDR_W) begin : g_drop
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^lsu_addr_i[CORE_ADDR_W-1:ADDR_W];
    end

    always_ff @(posedge lsu_clk_i) begin
        if (lsu_rst_i) r_state <= ST_IDLE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next        = r_state;
        axi_arvalid_o = 1'b0;
        axi_rready_o  = 1'b0;
        axi_awvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_bready_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (lsu_wen_i)      w_next = ST_WREQ;
                else if (lsu_ren_i) w_next = ST_RADDR;
            end
            ST_RADDR: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i) w_next = ST_RDATA;
            end
            ST_RDATA: begin
                axi_rready_o = 1'b1;
                if (axi_rvalid_i) w_next = ST_IDLE;
            end
            ST_WREQ: begin
                axi_awvalid_o = !r_aw_done;
                axi_wvalid_o  = !r_w_done;
                if ((r_aw_done || axi_awready_i) && (r_w_done || axi_wready_i))
                    w_next = ST_WRESP;
            end
            ST_WRESP: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_ar_hs  = axi_arvalid_o && axi_arready_i;
    assign w_r_hs   = axi_rready_o  && axi_rvalid_i;
    assign w_aw_hs  = axi_awvalid_o && axi_awready_i;
    assign w_w_hs   = axi_wvalid_o  && axi_wready_i;
    assign w_b_hs   = axi_bready_o  && axi_bvalid_i;
    assign w_accept = (r_state == ST_IDLE) && (lsu_ren_i || lsu_wen_i);

    always_ff @(posedge lsu_clk_i) begin
        if (lsu_rst_i) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wmask   <= '0;
            r_rdata   <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_done <= w_r_hs || w_b_hs;
            if (w_accept) begin
                r_addr <= lsu_addr_i[ADDR_W-1:0];
                if (lsu_wen_i) begin
                    r_wdata <= lsu_wdata_i;
                    r_wmask <= lsu_wmask_i;
                end
            end
            // Flags only matter inside WREQ; clearing elsewhere re-arms them per write.
            if (r_state != ST_WREQ) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
            if (w_r_hs) begin
                r_rdata <= axi_rdata_i;
                r_err   <= (axi_rresp_i != AXI_RESP_OKAY);
            end
            if (w_b_hs) r_err <= (axi_bresp_i != AXI_RESP_OKAY);
        end
    end

    assign lsu_rdata_o  = r_rdata;
    assign lsu_done_o   = r_done;
    assign lsu_err_o    = r_err;
    assign lsu_busy_o   = (r_state != ST_IDLE);
    assign axi_araddr_o = r_addr;
    assign axi_awaddr_o = r_addr;
    assign axi_wdata_o  = r_wdata;
    assign axi_wstrb_o  = r_wmask;

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// Directed plus randomized bench for lsu_axi_bridge; slave timing and expected
// outputs come from a per-transaction timeline derived from handshake offsets.
module tb_lsu_axi_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        ren, wen;
    logic [63:0] addr, wdata;
    logic [7:0]  wmask;
    logic [63:0] rdata_o;
    logic        done_o, busy_o, err_o;
    logic [31:0] araddr;
    logic        arvalid, arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid, rready;
    logic [31:0] awaddr;
    logic        awvalid, awready;
    logic [63:0] wdata_ax;
    logic [7:0]  wstrb;
    logic        wvalid, wready;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [63:0] m_rdata = '0;
    logic        m_err   = 1'b0;

    always #5 clk = ~clk;

    lsu_axi_bridge #(.ADDR_W(32), .DATA_W(64)) dut (
        .lsu_clk_i(clk), .lsu_rst_i(rst),
        .lsu_ren_i(ren), .lsu_wen_i(wen), .lsu_addr_i(addr),
        .lsu_wdata_i(wdata), .lsu_wmask_i(wmask),
        .lsu_rdata_o(rdata_o), .lsu_done_o(done_o), .lsu_busy_o(busy_o), .lsu_err_o(err_o),
        .axi_araddr_o(araddr), .axi_arvalid_o(arvalid), .axi_arready_i(arready),
        .axi_rdata_i(rdata), .axi_rresp_i(rresp), .axi_rvalid_i(rvalid), .axi_rready_o(rready),
        .axi_awaddr_o(awaddr), .axi_awvalid_o(awvalid), .axi_awready_i(awready),
        .axi_wdata_o(wdata_ax), .axi_wstrb_o(wstrb), .axi_wvalid_o(wvalid), .axi_wready_i(wready),
        .axi_bresp_i(bresp), .axi_bvalid_i(bvalid), .axi_bready_o(bready)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic slave_quiet();
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; bvalid = 1'b0;
        rdata = {$urandom, $urandom}; rresp = 2'($urandom); bresp = 2'($urandom);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(negedge clk);
            ren = 1'b0; wen = 1'b0;
            slave_quiet();
            chk("idle_done", 64'(done_o), 64'd0);
            chk("idle_busy", 64'(busy_o), 64'd0);
            chk("idle_valids", {61'd0, arvalid, awvalid, wvalid}, 64'd0);
            chk("idle_rdata", rdata_o, m_rdata);
            chk("idle_err", 64'(err_o), 64'(m_err));
        end
    endtask

    // Called at the negedge of the request cycle; returns at the negedge of the done cycle.
    task automatic run_txn(input bit is_wr, input bit both, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] m, input logic [1:0] resp,
                           input int unsigned d_a, input int unsigned d_w, input int unsigned d_resp);
        int unsigned t_a, t_w, t_last, t_resp, t_done;
        t_a    = 1 + d_a;
        t_w    = 1 + d_w;
        t_last = is_wr ? ((t_a > t_w) ? t_a : t_w) : t_a;
        t_resp = t_last + 1 + d_resp;
        t_done = t_resp + 1;

        ren = both || !is_wr; wen = is_wr;
        addr = a; wdata = d; wmask = m;
        slave_quiet();
        chk("req_busy", 64'(busy_o), 64'd0);

        for (int unsigned t = 1; t <= t_done; t++) begin
            @(negedge clk);
            if (t < t_done) begin
                ren = 1'($urandom); wen = 1'($urandom);
                addr = {$urandom, $urandom}; wdata = {$urandom, $urandom}; wmask = 8'($urandom);
            end else begin
                ren = 1'b0; wen = 1'b0;
            end
            slave_quiet();
            arready = !is_wr && (t == t_a);
            awready = is_wr && (t == t_a);
            wready  = is_wr && (t == t_w);
            rvalid  = !is_wr && (t == t_resp);
            bvalid  = is_wr && (t == t_resp);
            if (t == t_resp) begin
                rdata = d; rresp = resp; bresp = resp;
            end

            chk("arvalid", 64'(arvalid), 64'(!is_wr && t <= t_a));
            chk("rready",  64'(rready),  64'(!is_wr && t > t_a && t <= t_resp));
            chk("awvalid", 64'(awvalid), 64'(is_wr && t <= t_a));
            chk("wvalid",  64'(wvalid),  64'(is_wr && t <= t_w));
            chk("bready",  64'(bready),  64'(is_wr && t > t_last && t <= t_resp));
            chk("busy",    64'(busy_o),  64'(t < t_done));
            chk("done",    64'(done_o),  64'(t == t_done));
            if (t < t_done) begin
                if (is_wr) begin
                    chk("awaddr", 64'(awaddr), 64'(a[31:0]));
                    chk("wdata",  wdata_ax, d);
                    chk("wstrb",  64'(wstrb), 64'(m));
                end else begin
                    chk("araddr", 64'(araddr), 64'(a[31:0]));
                end
            end else begin
                if (!is_wr) m_rdata = d;
                m_err = (resp != 2'b00);
            end
            chk("rdata_o", rdata_o, m_rdata);
            chk("err_o", 64'(err_o), 64'(m_err));
        end
    endtask

    initial begin
        rst = 1'b1; ren = 1'b0; wen = 1'b0;
        addr = '0; wdata = '0; wmask = '0;
        slave_quiet();
        repeat (3) @(negedge clk);
        chk("rst_rdata", rdata_o, 64'd0);
        chk("rst_flags", {60'd0, done_o, busy_o, err_o, 1'b0}, 64'd0);
        chk("rst_valid", {59'd0, arvalid, rready, awvalid, wvalid, bready}, 64'd0);
        chk("rst_addr", {araddr, awaddr}, 64'd0);
        chk("rst_wdata", wdata_ax, 64'd0);
        chk("rst_wstrb", 64'(wstrb), 64'd0);
        rst = 1'b0;
        idle(1);

        // Zero-wait read.
        run_txn(1'b0, 1'b0, 64'h0000_0000_8000_0010, 64'h1122334455667788, 8'h00, 2'b00, 0, 0, 0);
        idle(1);
        // Write with AW accepted three cycles late, W immediately.
        run_txn(1'b1, 1'b0, 64'h0000_0000_8000_0100, 64'h0000_0000_DEAD_BEEF, 8'h0F, 2'b00, 3, 0, 0);
        idle(1);
        // Simultaneous read and write request: write wins.
        run_txn(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hCAFE_F00D_1234_5678, 8'hFF, 2'b00, 0, 0, 0);
        idle(2);
        // Error write followed by a clean read.
        run_txn(1'b1, 1'b0, 64'hFFFF_0000_1000_0008, 64'h0102030405060708, 8'h00, 2'b10, 0, 2, 1);
        run_txn(1'b0, 1'b0, 64'h0000_0001_2000_0040, 64'hA5A5_5A5A_0F0F_F0F0, 8'h00, 2'b00, 1, 0, 2);
        idle(1);

        // Reset while waiting in RDATA.
        @(negedge clk);
        ren = 1'b1; addr = 64'h0000_0000_3000_0000; slave_quiet();
        @(negedge clk);
        ren = 1'b0; slave_quiet(); arready = 1'b1;
        chk("rst_mid_arvalid", 64'(arvalid), 64'd1);
        @(negedge clk);
        slave_quiet();
        chk("rst_mid_rready", 64'(rready), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; slave_quiet();
        m_rdata = '0; m_err = 1'b0;
        chk("rst_mid_busy", 64'(busy_o), 64'd0);
        chk("rst_mid_rready0", 64'(rready), 64'd0);
        chk("rst_mid_done", 64'(done_o), 64'd0);
        chk("rst_mid_rdata", rdata_o, 64'd0);
        idle(1);
        run_txn(1'b0, 1'b0, 64'h0000_0000_3000_0008, 64'h7766554433221100, 8'h00, 2'b00, 0, 0, 0);

        // Back-to-back: next request issued in the done cycle.
        run_txn(1'b0, 1'b0, 64'h0000_0000_4000_0000, 64'h1357_9BDF_2468_ACE0, 8'h00, 2'b00, 0, 0, 0);
        run_txn(1'b1, 1'b0, 64'h0000_0000_4000_0010, 64'h0, 8'h00, 2'b00, 1, 1, 0);
        run_txn(1'b0, 1'b0, 64'h0000_0000_4000_0020, 64'hFEDC_BA98_7654_3210, 8'h00, 2'b11, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 24; i++) begin
            bit          r_is_wr, r_both;
            logic [1:0]  r_resp;
            r_is_wr = 1'($urandom);
            r_both  = r_is_wr && 1'($urandom);
            r_resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(r_is_wr, r_both, {$urandom, $urandom}, {$urandom, $urandom}, 8'($urandom),
                    r_resp, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        end
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
